single_add_v_s_seq: RTL and testbench
=====================================

// Module: single_add_v_s_seq
// PURPOSE
//  Time-multiplexed sequencer for vector+scalar single-precision add: c[i] = a[i] + b.
//  Shares ONE external single_add_1clk-style adder across WIDTH elements instead of WIDTH adders.
//  Issues one element per cycle, collects results in order, pulses done when the vector is complete.
//  Sits between layer control (start/done) and the shared FP adder; area-saving replacement for the parallel array.
// PARAMETERS
//  WIDTH           10  number of vector elements (>=1)
//  TIMEOUT_CYCLES  16  max cycles between results before abort (used only with SINGLE_ADD_SEQ_TIMEOUT_EN)
// PORTS
//  clk            in   1          clock, all logic on rising edge
//  rst            in   1          synchronous reset, active-high
//  start          in   1          request; sampled only in IDLE
//  vector_a       in   32 x WIDTH operand vector (unpacked [WIDTH]), captured on accepted start
//  b              in   32         scalar operand, captured on accepted start
//  busy           out  1          high in any state other than IDLE
//  done           out  1          one-cycle pulse: vector_c complete and valid
//  error          out  1          one-cycle pulse on timeout abort (tied 0 without macro)
//  vector_c       out  32 x WIDTH result vector (unpacked [WIDTH]), registered
//  add_in_valid   out  1          to adder: operands valid this cycle
//  add_a          out  32         to adder: element a[issue_idx]
//  add_b          out  32         to adder: captured b
//  add_out_valid  in   1          from adder: result valid
//  add_c          in   32         from adder: result
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE; busy=0, done=0, error=0, add_in_valid=0, add_a=0, add_b=0, vector_c all 0, counters 0.
//  Reset mid-operation aborts immediately; in-flight adder results after reset are ignored (IDLE).
//  FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//   IDLE : start=1 at edge -> capture vector_a[0..WIDTH-1] and b into local regs, issue_idx=0, rcv_idx=0 -> ISSUE.
//   ISSUE: add_in_valid=1, add_a=a_reg[issue_idx], add_b=b_reg; issue_idx++ every cycle (no stall);
//          after issue_idx=WIDTH-1 is issued -> DRAIN (WIDTH consecutive add_in_valid cycles).
//   DRAIN: add_in_valid=0; wait until rcv_idx reaches WIDTH -> DONE.
//   DONE : done=1 for exactly one cycle -> IDLE. vector_c holds until next accepted start writes over it.
//  Result capture (ISSUE or DRAIN): add_out_valid=1 -> vector_c[rcv_idx] <= add_c, rcv_idx++.
//   Results assumed in issue order (adder is in-order pipeline). Results may arrive while still issuing.
//   add_out_valid when rcv_idx==WIDTH, or in IDLE/DONE: ignored, no write.
//  Counters: issue_idx, rcv_idx width $clog2(WIDTH+1); no wrap beyond WIDTH.
//  start while busy: ignored (no queueing). start in DONE cycle: ignored; must be re-presented in IDLE.
//  Latency: with adder latency L, start edge at cycle 0 -> issue cycles 1..WIDTH -> done high cycle WIDTH+L+1.
//  WIDTH=1: single issue cycle, then DRAIN.
//  add_a/add_b hold last driven values when add_in_valid=0 (don't-care to adder).
//  No floating-point arithmetic inside this block; pure sequencing/muxing.
// CONFIGURATION
//  SINGLE_ADD_SEQ_TIMEOUT_EN defined:
//   watchdog counter cleared on each add_out_valid and on entering ISSUE; counts in ISSUE/DRAIN while rcv_idx<WIDTH.
//   Reaching TIMEOUT_CYCLES -> error=1 one cycle, done NOT asserted, go IDLE; vector_c keeps partial contents.
//  Not defined: no watchdog; DRAIN waits indefinitely; error constantly 0; no counter logic synthesized.
// TESTING  (bench uses a behavioural 1-cycle-latency FP adder model)
//  1 WIDTH=4, a={3F800000,40000000,40400000,40800000}, b=3F800000, start pulse -> add_in_valid 4 cycles,
//    done at cycle 6, vector_c={40000000,40400000,40800000,40A00000}, busy high cycles 1..5.
//  2 Assert start every cycle during run -> exactly one done per run; second run starts only from IDLE,
//    captured operands unchanged when vector_a changes mid-run.
//  3 rst=1 during ISSUE (after 2 issues) -> next cycle busy=0, vector_c all 0, no done; model's trailing
//    add_out_valid ignored; new start then completes normally.
//  4 Adder model latency 3, WIDTH=10, b=0 -> done at cycle 14, vector_c == a; spurious add_out_valid in IDLE -> no write.
//  5 WIDTH=1, a=BF800000, b=3F800000 -> one issue, vector_c[0]=00000000, done at cycle 3.
//  6 With SINGLE_ADD_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16: model drops last result -> error pulse 16 cycles
//    after prior result, no done, busy=0 after; without macro same stimulus -> busy stays 1, error=0.

Source files
------------

// File: rtl/single_add_v_s_seq.sv
// Time-multiplexed vector+scalar sequencer: feeds a[i] and b to one shared FP adder, one element per cycle,
// and collects the in-order results into vector_c. Define SINGLE_ADD_SEQ_TIMEOUT_EN to add a result watchdog.
module single_add_v_s_seq #(
    parameter int WIDTH          = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] vector_a [WIDTH],
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] vector_c [WIDTH],
    output logic        add_in_valid,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic        add_out_valid,
    input  logic [31:0] add_c
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] issue_idx;
    logic [CW-1:0] rcv_idx;
    logic [CW-1:0] issue_nxt;
    logic [31:0]   a_reg [WIDTH];
    logic          active;
    logic          accept;
    logic          capture;
    logic          wd_fire;

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign active    = (state == S_ISSUE) || (state == S_DRAIN);
    assign accept    = (state == S_IDLE) && start;
    assign capture   = active && add_out_valid && (rcv_idx != FULL);
    assign issue_nxt = issue_idx + CW'(1);

`ifdef SINGLE_ADD_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt;
    logic          err_q;

    // Fires on the cycle the silent-period count would reach TIMEOUT_CYCLES.
    assign wd_fire = active && !add_out_valid && (rcv_idx != FULL) &&
                     (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign error   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= wd_fire;
            if (accept || wd_fire || (active && add_out_valid)) begin
                wd_cnt <= '0;
            end else if (active && (rcv_idx != FULL)) begin
                wd_cnt <= wd_cnt + TW'(1);
            end
        end
    end
`else
    assign wd_fire = 1'b0;
    assign error   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            issue_idx    <= '0;
            rcv_idx      <= '0;
            add_in_valid <= 1'b0;
            add_a        <= '0;
            add_b        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_ISSUE;
                        issue_idx    <= '0;
                        rcv_idx      <= '0;
                        add_in_valid <= 1'b1;
                        add_a        <= vector_a[0];
                        add_b        <= b;
                    end
                end
                S_ISSUE: begin
                    if (wd_fire) begin
                        state        <= S_IDLE;
                        add_in_valid <= 1'b0;
                    end else if (issue_idx == LAST) begin
                        state        <= S_DRAIN;
                        add_in_valid <= 1'b0;
                        issue_idx    <= FULL;
                    end else begin
                        issue_idx <= issue_nxt;
                        add_a     <= a_reg[IW'(issue_nxt)];
                    end
                end
                S_DRAIN: begin
                    if (wd_fire) begin
                        state <= S_IDLE;
                    end else if (rcv_idx == FULL) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (capture) begin
                rcv_idx <= rcv_idx + CW'(1);
            end
        end
    end

    // Operand snapshot: later changes on vector_a do not affect a run in progress.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= vector_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                vector_c[i] <= '0;
            end
        end else if (capture) begin
            vector_c[IW'(rcv_idx)] <= add_c;
        end
    end

endmodule

// File: tb/tb_single_add_v_s_seq.sv
// Directed bench for single_add_v_s_seq: three instances (WIDTH 4/10/1) each driving a behavioural FP adder.
`timescale 1ns/1ps
module tb_single_add_v_s_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int n_chk = 0;
    int n_err = 0;
    int n_iv, n_dn, dn_at, bad, n_ep, ep_at;
    logic [31:0] iss [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic real sp2r(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // WIDTH=4 instance, adder latency 1, optional result drop
    logic        st4, busy4, done4, err4, iv4, ov4, drop4;
    logic [31:0] va4 [4];
    logic [31:0] vc4 [4];
    logic [31:0] b4, aa4, ab4, c4;
    always @(posedge clk) begin
        ov4 <= iv4 && !drop4;
        c4  <= r2sp(sp2r(aa4) + sp2r(ab4));
    end
    single_add_v_s_seq #(.WIDTH(4), .TIMEOUT_CYCLES(16)) u4 (
        .clk(clk), .rst(rst), .start(st4), .vector_a(va4), .b(b4),
        .busy(busy4), .done(done4), .error(err4), .vector_c(vc4),
        .add_in_valid(iv4), .add_a(aa4), .add_b(ab4),
        .add_out_valid(ov4), .add_c(c4));

    // WIDTH=10 instance, adder latency 3, forced spurious results
    logic        st10, busy10, done10, err10, iv10, ov10, frc10v;
    logic [31:0] va10 [10];
    logic [31:0] vc10 [10];
    logic [31:0] b10, aa10, ab10, c10, frc10c;
    logic        p10v [3] = '{default: 1'b0};
    logic [31:0] p10c [3];
    always @(posedge clk) begin
        p10v[0] <= iv10;
        p10c[0] <= r2sp(sp2r(aa10) + sp2r(ab10));
        p10v[1] <= p10v[0];
        p10c[1] <= p10c[0];
        p10v[2] <= p10v[1];
        p10c[2] <= p10c[1];
    end
    assign ov10 = p10v[2] | frc10v;
    assign c10  = frc10v ? frc10c : p10c[2];
    single_add_v_s_seq #(.WIDTH(10), .TIMEOUT_CYCLES(16)) u10 (
        .clk(clk), .rst(rst), .start(st10), .vector_a(va10), .b(b10),
        .busy(busy10), .done(done10), .error(err10), .vector_c(vc10),
        .add_in_valid(iv10), .add_a(aa10), .add_b(ab10),
        .add_out_valid(ov10), .add_c(c10));

    // WIDTH=1 instance, adder latency 1
    logic        st1, busy1, done1, err1, iv1, ov1;
    logic [31:0] va1 [1];
    logic [31:0] vc1 [1];
    logic [31:0] b1, aa1, ab1, c1;
    always @(posedge clk) begin
        ov1 <= iv1;
        c1  <= r2sp(sp2r(aa1) + sp2r(ab1));
    end
    single_add_v_s_seq #(.WIDTH(1), .TIMEOUT_CYCLES(16)) u1 (
        .clk(clk), .rst(rst), .start(st1), .vector_a(va1), .b(b1),
        .busy(busy1), .done(done1), .error(err1), .vector_c(vc1),
        .add_in_valid(iv1), .add_a(aa1), .add_b(ab1),
        .add_out_valid(ov1), .add_c(c1));

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; st4 = 0; st10 = 0; st1 = 0; drop4 = 0; frc10v = 0; frc10c = 0;
        va4 = '{default: 32'd0}; va10 = '{default: 32'd0}; va1 = '{default: 32'd0};
        b4 = 0; b10 = 0; b1 = 0;
        repeat (3) tick();
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_done4", 32'(done4), 32'd0);
        chk("rst_err4", 32'(err4), 32'd0);
        chk("rst_iv4", 32'(iv4), 32'd0);
        chk("rst_add_a4", aa4, 32'd0);
        chk("rst_add_b4", ab4, 32'd0);
        chk("rst_vc4_3", vc4[3], 32'd0);
        chk("rst_busy10", 32'(busy10), 32'd0);
        chk("rst_vc1_0", vc1[0], 32'd0);
        rst = 1'b0;
        tick();

        // Test 1: basic WIDTH=4 run
        va4 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        b4 = 32'h3F800000; st4 = 1;
        n_iv = 0; n_dn = 0; dn_at = -1; bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 0) st4 = 0;
            if (iv4) begin
                if (n_iv < 8) iss[n_iv] = aa4;
                n_iv++;
            end
            if (done4) begin n_dn++; dn_at = k; end
            if ((k >= 1 && k <= 5 && !busy4) || (k >= 8 && busy4)) bad++;
        end
        chk("t1_issue_count", n_iv, 4);
        chk("t1_issue0", iss[0], 32'h3F800000);
        chk("t1_issue3", iss[3], 32'h40800000);
        chk("t1_add_b", ab4, 32'h3F800000);
        chk("t1_done_count", n_dn, 1);
        chk("t1_done_cycle", dn_at, 6);
        chk("t1_busy_profile", bad, 0);
        chk("t1_c0", vc4[0], 32'h40000000);
        chk("t1_c1", vc4[1], 32'h40400000);
        chk("t1_c2", vc4[2], 32'h40800000);
        chk("t1_c3", vc4[3], 32'h40A00000);

        // Test 2: start held high, operands change mid-run
        va4 = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
        st4 = 1; n_dn = 0; dn_at = -1; ep_at = -1;
        for (int k = 0; k < 18; k++) begin
            tick();
            if (k == 2) va4 = '{default: 32'h3F800000};
            if (k == 8) st4 = 0;
            if (done4) begin
                n_dn++;
                if (dn_at < 0) dn_at = k; else ep_at = k;
            end
            if (k == 7) begin
                chk("t2_run1_c0", vc4[0], 32'h40400000);
                chk("t2_run1_c3", vc4[3], 32'h40C00000);
            end
        end
        chk("t2_done_count", n_dn, 2);
        chk("t2_done1_cycle", dn_at, 6);
        chk("t2_done2_cycle", ep_at, 14);
        chk("t2_run2_c0", vc4[0], 32'h40000000);
        chk("t2_run2_c3", vc4[3], 32'h40000000);

        // Test 3: reset during ISSUE after two issues
        va4 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        st4 = 1; n_dn = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k == 0) st4 = 0;
            if (k == 1) rst = 1;
            if (k == 2) begin
                rst = 0;
                chk("t3_busy_after_rst", 32'(busy4), 32'd0);
                chk("t3_iv_after_rst", 32'(iv4), 32'd0);
            end
            if (done4) n_dn++;
        end
        chk("t3_no_done", n_dn, 0);
        chk("t3_c0_zero", vc4[0], 32'd0);
        chk("t3_c1_zero", vc4[1], 32'd0);
        st4 = 1; n_dn = 0; dn_at = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 0) st4 = 0;
            if (done4) begin n_dn++; dn_at = k; end
        end
        chk("t3_rerun_done", dn_at, 6);
        chk("t3_rerun_c0", vc4[0], 32'h40000000);
        chk("t3_rerun_c3", vc4[3], 32'h40A00000);

        // Test 4: WIDTH=10, adder latency 3, b=0
        va10 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
        b10 = 32'd0; st10 = 1; n_dn = 0; dn_at = -1; n_iv = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 0) st10 = 0;
            if (iv10) n_iv++;
            if (done10) begin n_dn++; dn_at = k; end
        end
        chk("t4_issue_count", n_iv, 10);
        chk("t4_done_count", n_dn, 1);
        chk("t4_done_cycle", dn_at, 14);
        for (int i = 0; i < 10; i++) chk($sformatf("t4_c%0d", i), vc10[i], va10[i]);
        frc10v = 1; frc10c = 32'hDEADBEEF;
        tick();
        frc10v = 0;
        tick();
        chk("t4_spurious_c0", vc10[0], 32'h3F800000);
        chk("t4_spurious_busy", 32'(busy10), 32'd0);

        // Test 5: WIDTH=1
        for (int r = 0; r < 2; r++) begin
            va1[0] = (r == 0) ? 32'h3F800000 : 32'hBF800000;
            b1 = 32'h3F800000; st1 = 1; n_dn = 0; dn_at = -1; n_iv = 0;
            for (int k = 0; k < 7; k++) begin
                tick();
                if (k == 0) st1 = 0;
                if (iv1) n_iv++;
                if (done1) begin n_dn++; dn_at = k; end
            end
            chk($sformatf("t5_r%0d_issue_count", r), n_iv, 1);
            chk($sformatf("t5_r%0d_done_cycle", r), dn_at, 3);
            chk($sformatf("t5_r%0d_c0", r), vc1[0], (r == 0) ? 32'h40000000 : 32'h00000000);
        end

        // Test 6: last result dropped by the adder
        va4 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        st4 = 1; n_dn = 0; n_ep = 0; ep_at = -1;
        for (int k = 0; k < 27; k++) begin
            tick();
            if (k == 0) st4 = 0;
            if (k == 3) drop4 = 1;
            if (k == 4) drop4 = 0;
            if (done4) n_dn++;
            if (err4) begin n_ep++; ep_at = k; end
        end
        chk("t6_no_done", n_dn, 0);
        chk("t6_partial_c2", vc4[2], 32'h40800000);
`ifdef SINGLE_ADD_SEQ_TIMEOUT_EN
        chk("t6_error_count", n_ep, 1);
        chk("t6_error_cycle", ep_at, 20);
        chk("t6_busy_after", 32'(busy4), 32'd0);
`else
        chk("t6_error_count", n_ep, 0);
        chk("t6_busy_stuck", 32'(busy4), 32'd1);
`endif
        rst = 1;
        tick();
        rst = 0;
        chk("t6_busy_after_rst", 32'(busy4), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
